// File: rtl/blink_seg_scan.sv
// blink_seg_scan: 4-digit common-anode 7-seg scanner with guard time and edit-field blink blanking; in: clk, rst_n, blink, digits[15:0], dp_in[3:0], edit_sel[1:0]; out (active-low): an[3:0], seg[6:0], dp
module blink_seg_scan #(
   parameter int REFRESH_DIV = 50000,
   parameter int GUARD       = 16,
   parameter int CNT_W       = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        blink,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_in,
   input  logic [1:0]  edit_sel,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);
   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx;
   logic             b1, b2, off, last;
   logic [3:0]       cur;
   logic [6:0]       dec;
   always_comb begin
      cur  = digits[{idx, 2'b00} +: 4];
      last = cnt == CNT_W'(REFRESH_DIV - 1);
      off  = cnt < CNT_W'(GUARD) ||
             (!b2 && (edit_sel == 2'd3 || (edit_sel == 2'd1 && !idx[1]) || (edit_sel == 2'd2 && idx[1])));
      case (cur)
         4'd0:    dec = 7'b1000000;
         4'd1:    dec = 7'b1111001;
         4'd2:    dec = 7'b0100100;
         4'd3:    dec = 7'b0110000;
         4'd4:    dec = 7'b0011001;
         4'd5:    dec = 7'b0010010;
         4'd6:    dec = 7'b0000010;
         4'd7:    dec = 7'b1111000;
         4'd8:    dec = 7'b0000000;
         4'd9:    dec = 7'b0010000;
         default: dec = 7'b0111111;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
         b1  <= 1'b0;
         b2  <= 1'b0;
         an  <= 4'hF;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         b1  <= blink;
         b2  <= b1;
         cnt <= last ? '0 : cnt + 1'b1;
         idx <= last ? idx + 1'b1 : idx;
         an  <= off ? 4'hF : ~(4'b0001 << idx);
         seg <= off ? 7'h7F : dec;
         dp  <= off | ~dp_in[idx];
      end
   end
endmodule

// File: tb/tb_blink_seg_scan.sv
// tb_blink_seg_scan: scoreboard bench for blink_seg_scan with a cycle-count reference model
module tb_blink_seg_scan;
   localparam int RD = 8;
   localparam int GD = 2;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        blink = 1'b1;
   logic [15:0] digits = 16'h1234;
   logic [3:0]  dp_in = 4'h0;
   logic [1:0]  edit_sel = 2'd0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   int checks = 0;
   int fails = 0;
   logic [11:0] exp_q[$];
   logic        blink_hist[$];
   int          n = 0;
   logic        win = 1'b0;
   int          hits = 0;
   logic [6:0]  seg_tbl[16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

   blink_seg_scan #(.REFRESH_DIV(RD), .GUARD(GD), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .blink(blink), .digits(digits), .dp_in(dp_in),
      .edit_sel(edit_sel), .an(an), .seg(seg), .dp(dp)
   );

   always #5 clk = ~clk;

   // Model: n counts clean cycles since reset; slot position and digit follow by division.
   always @(posedge clk) begin
      int pos, d;
      logic b, blank;
      if (!rst_n) begin
         exp_q.push_back({4'hF, 7'h7F, 1'b1});
         n = 0;
         blink_hist = '{1'b0, 1'b0};
      end else begin
         b = blink_hist.pop_front();
         blink_hist.push_back(blink);
         pos = n % RD;
         d = (n / RD) % 4;
         blank = !b && (edit_sel == 3 || (edit_sel == 1 && d < 2) || (edit_sel == 2 && d >= 2));
         if (pos < GD || blank) exp_q.push_back({4'hF, 7'h7F, 1'b1});
         else exp_q.push_back({~(4'b0001 << d), seg_tbl[(digits >> (4 * d)) & 16'hF], ~dp_in[d]});
         n++;
      end
   end

   always @(posedge clk) begin
      logic [11:0] e;
      #1;
      checks++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL out: no expected entry, got an=%b seg=%b dp=%b", an, seg, dp);
      end else begin
         e = exp_q.pop_front();
         if ({an, seg, dp} !== e) begin
            fails++;
            $display("FAIL out @%0t: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     $time, an, seg, dp, e[11:8], e[7:1], e[0]);
         end
      end
      checks++;
      if ($countones(~an) > 1) begin
         fails++;
         $display("FAIL onehot @%0t: an=%b has more than one low bit", $time, an);
      end
      if (win && an == 4'b1110) hits++;
   end

   task automatic cyc(input int k);
      repeat (k) @(negedge clk);
   endtask

   initial begin
      cyc(3);
      rst_n = 1'b1;
      cyc(40);
      hits = 0;
      win = 1'b1;
      cyc(4 * RD);
      win = 1'b0;
      checks++;
      if (hits != RD - GD) begin
         fails++;
         $display("FAIL scan_count: got %0d cycles of an=1110, want %0d", hits, RD - GD);
      end
      digits = 16'h00AF;
      dp_in = 4'b0100;
      cyc(40);
      edit_sel = 2'd1;
      blink = 1'b0;
      cyc(64);
      blink = 1'b1;
      cyc(32);
      edit_sel = 2'd3;
      for (int i = 0; i < 4; i++) begin
         blink = ~blink;
         cyc(40);
      end
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      cyc(2 * RD + 4);
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      cyc(40);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) digits = 16'($urandom);
         if ($urandom_range(0, 7) == 0) dp_in = 4'($urandom);
         if ($urandom_range(0, 49) == 0) edit_sel = 2'($urandom);
         if ($urandom_range(0, 19) == 0) blink = ~blink;
         rst_n = $urandom_range(0, 499) != 0;
         cyc(1);
      end
      rst_n = 1'b1;
      cyc(2);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
